instr_buffer: RTL and testbench

INSTR_BUFFER -- requirements
Module: instr_buffer

---
 rtl/instr_buffer.sv | 97 +++++++++
 tb/tb_instr_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO that packs the
// valid slots of each fetch group and presents up to DECODE_WIDTH entries per cycle.
module instr_buffer #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DECODE_WIDTH    = 4,
  parameter int DEPTH           = 16,
  parameter int XLEN            = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   fe_valid_i,
  output logic                                   fe_ready_o,
  input  logic [INSTR_PER_FETCH-1:0]             fe_slot_valid_i,
  input  logic [INSTR_PER_FETCH-1:0][XLEN-1:0]   fe_pc_i,
  input  logic [INSTR_PER_FETCH-1:0][XLEN-1:0]   fe_instr_i,
  input  logic [INSTR_PER_FETCH-1:0][XLEN-1:0]   fe_pred_npc_i,
  output logic [DECODE_WIDTH-1:0]                de_valid_o,
  output logic [DECODE_WIDTH-1:0][XLEN-1:0]      de_pc_o,
  output logic [DECODE_WIDTH-1:0][XLEN-1:0]      de_instr_o,
  output logic [DECODE_WIDTH-1:0][XLEN-1:0]      de_pred_npc_o,
  input  logic                                   de_ready_i,
  output logic [$clog2(DEPTH):0]                 count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] npc_mem   [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          push_fire, pop_fire;
  logic [CW-1:0] push_cnt, pop_cnt, free;
  logic [PW-1:0] slot_idx [INSTR_PER_FETCH];

  // Ready depends only on registered occupancy so fetch never sees a path from decode.
  assign free       = CW'(DEPTH) - count;
  assign fe_ready_o = free >= CW'(INSTR_PER_FETCH);
  assign push_fire  = fe_valid_i & fe_ready_o & ~flush_i & ~rst_i;
  assign pop_fire   = de_ready_i & ~flush_i & ~rst_i;
  assign pop_cnt    = (count > CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : count;
  assign count_o    = count;

  // Each valid slot lands at wr_ptr plus the number of valid slots below it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      slot_idx[i] = wr_ptr + push_cnt[PW-1:0];
      if (fe_slot_valid_i[i]) push_cnt = push_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + push_cnt[PW-1:0];
      if (pop_fire)  rd_ptr <= rd_ptr + pop_cnt[PW-1:0];
      count <= count + (push_fire ? push_cnt : '0) - (pop_fire ? pop_cnt : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        if (fe_slot_valid_i[i]) begin
          pc_mem[slot_idx[i]]    <= fe_pc_i[i];
          instr_mem[slot_idx[i]] <= fe_instr_i[i];
          npc_mem[slot_idx[i]]   <= fe_pred_npc_i[i];
        end
      end
    end
  end

  // Lanes show pre-cycle contents only; invalid lanes are forced to zero.
  always_comb begin
    de_valid_o    = '0;
    de_pc_o       = '0;
    de_instr_o    = '0;
    de_pred_npc_o = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (count > CW'(k)) begin
        de_valid_o[k]    = 1'b1;
        de_pc_o[k]       = pc_mem[rd_ptr + PW'(k)];
        de_instr_o[k]    = instr_mem[rd_ptr + PW'(k)];
        de_pred_npc_o[k] = npc_mem[rd_ptr + PW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: fill/drain, holes, full, wrap, flush and reset.
module tb_instr_buffer;

  logic                  clk = 1'b0;
  logic                  rst_i, flush_i, fe_valid_i, de_ready_i;
  logic                  fe_ready_o;
  logic [3:0]            fe_slot_valid_i;
  logic [3:0][31:0]      fe_pc_i, fe_instr_i, fe_pred_npc_i;
  logic [3:0]            de_valid_o;
  logic [3:0][31:0]      de_pc_o, de_instr_o, de_pred_npc_o;
  logic [4:0]            count_o;

  int total = 0;
  int bad   = 0;

  instr_buffer dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o),
    .fe_slot_valid_i(fe_slot_valid_i), .fe_pc_i(fe_pc_i),
    .fe_instr_i(fe_instr_i), .fe_pred_npc_i(fe_pred_npc_i),
    .de_valid_o(de_valid_o), .de_pc_o(de_pc_o), .de_instr_o(de_instr_o),
    .de_pred_npc_o(de_pred_npc_o), .de_ready_i(de_ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slot i carries pc=base+4i, instr=pc^A5A50000, pred_npc=pc+0x1000.
  task automatic set_group(input logic [3:0] mask, input logic [31:0] base);
    fe_slot_valid_i = mask;
    for (int i = 0; i < 4; i++) begin
      fe_pc_i[i]       = base + 32'(4 * i);
      fe_instr_i[i]    = (base + 32'(4 * i)) ^ 32'hA5A5_0000;
      fe_pred_npc_i[i] = base + 32'(4 * i) + 32'h1000;
    end
  endtask

  task automatic push(input logic [3:0] mask, input logic [31:0] base);
    set_group(mask, base);
    fe_valid_i = 1'b1;
    tick();
    fe_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; fe_valid_i = 1'b0; de_ready_i = 1'b0;
    set_group(4'b0000, 32'h0);
    tick(); tick();
    rst_i = 1'b0;
    check("rst_count", count_o, 5'd0);
    check("rst_valid", de_valid_o, 4'b0000);
    check("rst_ready", fe_ready_o, 1'b1);

    // Full group, lanes in order
    push(4'b1111, 32'h8000_0000);
    check("full_valid", de_valid_o, 4'b1111);
    check("full_count", count_o, 5'd4);
    for (int k = 0; k < 4; k++)
      check("full_pc", de_pc_o[k], 32'h8000_0000 + 32'(4 * k));
    check("full_instr2", de_instr_o[2], 32'h8000_0008 ^ 32'hA5A5_0000);
    de_ready_i = 1'b1; tick(); de_ready_i = 1'b0;
    check("drain_count", count_o, 5'd0);

    // Holes compacted
    push(4'b1010, 32'h0000_0100);
    check("hole_valid", de_valid_o, 4'b0011);
    check("hole_pc0", de_pc_o[0], 32'h104);
    check("hole_pc1", de_pc_o[1], 32'h10C);
    check("hole_npc0", de_pred_npc_o[0], 32'h1104);
    check("hole_npc1", de_pred_npc_o[1], 32'h110C);
    check("hole_pc2_zero", de_pc_o[2], 32'h0);
    check("hole_count", count_o, 5'd2);
    de_ready_i = 1'b1; tick(); de_ready_i = 1'b0;
    check("hole_drain", count_o, 5'd0);

    // Zero-mask group changes nothing
    push(4'b0000, 32'h0000_0200);
    check("zero_count", count_o, 5'd0);
    check("zero_valid", de_valid_o, 4'b0000);

    // Fill to full, extra group rejected, one pop reopens
    for (int g = 0; g < 4; g++) push(4'b1111, 32'h200 + 32'(16 * g));
    check("fill_count", count_o, 5'd16);
    check("fill_ready", fe_ready_o, 1'b0);
    push(4'b1111, 32'h240);
    check("over_count", count_o, 5'd16);
    set_group(4'b1111, 32'h240);
    fe_valid_i = 1'b1; de_ready_i = 1'b1; tick();
    fe_valid_i = 1'b0; de_ready_i = 1'b0;
    check("pop_count", count_o, 5'd12);
    check("pop_ready", fe_ready_o, 1'b1);
    check("pop_pc0", de_pc_o[0], 32'h210);

    // Flush, then build occupancy 6 and stream across the wrap point
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check("flush1_count", count_o, 5'd0);
    push(4'b1111, 32'h300);
    push(4'b0011, 32'h310);
    check("six_count", count_o, 5'd6);
    for (int i = 0; i < 8; i++) begin
      set_group(4'b1111, 32'h318 + 32'(16 * i));
      fe_valid_i = 1'b1; de_ready_i = 1'b1;
      tick();
      check("stream_count", count_o, 5'd6);
      check("stream_pc0", de_pc_o[0], 32'h300 + 32'(16 * (i + 1)));
      check("stream_pc3", de_pc_o[3], 32'h30C + 32'(16 * (i + 1)));
    end
    fe_valid_i = 1'b0; de_ready_i = 1'b0;

    // Flush wins over simultaneous push and pop
    push(4'b1111, 32'h398);
    check("ten_count", count_o, 5'd10);
    set_group(4'b1111, 32'h3A8);
    fe_valid_i = 1'b1; de_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    fe_valid_i = 1'b0; de_ready_i = 1'b0; flush_i = 1'b0;
    check("flush_count", count_o, 5'd0);
    check("flush_valid", de_valid_o, 4'b0000);
    check("flush_ready", fe_ready_o, 1'b1);
    push(4'b0100, 32'h500);
    check("post_flush_valid", de_valid_o, 4'b0001);
    check("post_flush_pc0", de_pc_o[0], 32'h508);
    check("post_flush_count", count_o, 5'd1);

    // Mid-operation reset with occupancy 7
    push(4'b1111, 32'h600);
    push(4'b0011, 32'h610);
    check("seven_count", count_o, 5'd7);
    set_group(4'b1111, 32'h700);
    rst_i = 1'b1; fe_valid_i = 1'b1;
    tick();
    rst_i = 1'b0; fe_valid_i = 1'b0;
    check("mrst_count", count_o, 5'd0);
    check("mrst_valid", de_valid_o, 4'b0000);
    check("mrst_ready", fe_ready_o, 1'b1);
    check("mrst_pc0_zero", de_pc_o[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
